// File: rtl/pc_fetch_controller_pkg.sv
// Shared state encoding and default geometry for the PC fetch controller.
package pc_fetch_controller_pkg;

    localparam int          PC_W_DEF     = 16;
    localparam int          STEP_DEF     = 4;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

endpackage

// File: rtl/pc_fetch_controller_pc_next_sel.sv
// Next-PC selection: hold, sequential step, redirect, or hold-with-misalign flag.
// Purely combinational; only acts while an instruction is issued and not stalled.
module pc_fetch_controller_pc_next_sel
    import pc_fetch_controller_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int STEP = STEP_DEF
) (
    input  state_t            state_i,
    input  logic              stall_i,
    input  logic              halt_req_i,
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_target_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic [PC_W-1:0]   pc_next_o,
    output logic              misalign_o
);

    logic [PC_W-1:0] pc_seq;

    assign pc_seq = pc_i + PC_W'(STEP);

    always_comb begin
        pc_next_o  = pc_i;
        misalign_o = 1'b0;
        if (state_i == S_ISSUE && !stall_i) begin
            // Halt still advances so resume continues with the following instruction.
            if (halt_req_i) begin
                pc_next_o = pc_seq;
            end else if (redirect_valid_i) begin
                if (redirect_target_i[1:0] != 2'b00) begin
                    misalign_o = 1'b1;
                end else begin
                    pc_next_o = redirect_target_i;
                end
            end else begin
                pc_next_o = pc_seq;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_controller.sv
// PC sequencer: req/ack instruction fetch, issue with stall, redirect, halt and sticky fault.
// Two cycles per instruction with zero-wait memory; PC advances on the edge leaving ISSUE.
module pc_fetch_controller
    import pc_fetch_controller_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int              STEP     = STEP_DEF,
    parameter int              TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_i,
    output logic [PC_W-1:0]   pc_next_o,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_ack_i,
    output logic              instr_valid_o,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_target_i,
    input  logic              halt_req_i,
    input  logic              resume_i,
    output logic              halted_o,
    output logic              fault_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] sel_pc_next;
    logic            misalign;

    pc_fetch_controller_pc_next_sel #(
        .PC_W (PC_W),
        .STEP (STEP)
    ) u_pc_next_sel (
        .state_i           (state_q),
        .stall_i           (stall_i),
        .halt_req_i        (halt_req_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .pc_i              (pc_i),
        .pc_next_o         (sel_pc_next),
        .misalign_o        (misalign)
    );

    // The PC register has no reset, so it is loaded through pc_next while rst is high.
    assign pc_next_o   = rst ? RESET_PC : sel_pc_next;
    assign imem_addr_o = pc_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        halted_o      = 1'b0;
        fault_o       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                cnt_d   = 8'd0;
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    state_d = S_ISSUE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ISSUE: begin
                instr_valid_o = 1'b1;
                if (!stall_i) begin
                    if (halt_req_i) begin
                        state_d = S_HALT;
                    end else if (misalign) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_FETCH;
                        cnt_d   = 8'd0;
                    end
                end
            end
            S_HALT: begin
                halted_o = 1'b1;
                if (resume_i) begin
                    state_d = S_FETCH;
                    cnt_d   = 8'd0;
                end
            end
            S_FAULT: begin
                fault_o = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Randomized and directed bench for pc_fetch_controller against a flag-based behavioural model.
module tb_pc_fetch_controller;

    localparam int          TIMEOUT = 15;
    localparam logic [15:0] RST_PC  = 16'h0000;

    logic        clk;
    logic        rst;
    logic [15:0] pc_q;
    logic [15:0] pc_next;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one flag per activity plus a miss counter and the architectural PC.
    bit          m_idle, m_fetch, m_issue, m_halt, m_fault;
    int          m_miss;
    logic [15:0] m_pc;

    pc_fetch_controller dut (
        .clk               (clk),
        .rst               (rst),
        .pc_i              (pc_q),
        .pc_next_o         (pc_next),
        .imem_req_o        (imem_req),
        .imem_addr_o       (imem_addr),
        .imem_ack_i        (imem_ack),
        .instr_valid_o     (instr_valid),
        .stall_i           (stall),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .halt_req_i        (halt_req),
        .resume_i          (resume),
        .halted_o          (halted),
        .fault_o           (fault)
    );

    // External PC register, no reset of its own.
    always @(posedge clk) pc_q <= pc_next;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle  = 1'b1;
        m_fetch = 1'b0;
        m_issue = 1'b0;
        m_halt  = 1'b0;
        m_fault = 1'b0;
        m_miss  = 0;
        m_pc    = RST_PC;
    endtask

    task automatic drive_idle();
        imem_ack        = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 16'h0000;
        halt_req        = 1'b0;
        resume          = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},    16'(imem_req),    16'h0);
        chk({tag, "_valid"},  16'(instr_valid), 16'h0);
        chk({tag, "_halted"}, 16'(halted),      16'h0);
        chk({tag, "_fault"},  16'(fault),       16'h0);
        chk({tag, "_pcnext"}, pc_next,          RST_PC);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive at negedge, check outputs, then advance the model at posedge.
    task automatic cycle(input bit ack, input bit st, input bit rv, input logic [15:0] rt,
                         input bit hr, input bit rs);
        logic [15:0] exp_nx;
        @(negedge clk);
        imem_ack        = ack;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        halt_req        = hr;
        resume          = rs;
        #1;
        exp_nx = m_pc;
        if (m_issue && !st) begin
            if (hr)                 exp_nx = m_pc + 16'd4;
            else if (rv) begin
                if (rt[1:0] == 2'b00) exp_nx = rt;
            end else                exp_nx = m_pc + 16'd4;
        end
        chk("imem_req",    16'(imem_req),    16'(m_fetch));
        chk("instr_valid", 16'(instr_valid), 16'(m_issue));
        chk("halted",      16'(halted),      16'(m_halt));
        chk("fault",       16'(fault),       16'(m_fault));
        chk("imem_addr",   imem_addr,        m_pc);
        chk("pc_next",     pc_next,          exp_nx);
        @(posedge clk);
        if (m_idle) begin
            m_idle  = 1'b0;
            m_fetch = 1'b1;
            m_miss  = 0;
        end else if (m_fetch) begin
            if (ack) begin
                m_fetch = 1'b0;
                m_issue = 1'b1;
            end else begin
                m_miss++;
                if (m_miss == TIMEOUT) begin
                    m_fetch = 1'b0;
                    m_fault = 1'b1;
                end
            end
        end else if (m_issue) begin
            if (!st) begin
                m_issue = 1'b0;
                if (hr)                        m_halt  = 1'b1;
                else if (rv && rt[1:0] != 2'b00) m_fault = 1'b1;
                else begin
                    m_fetch = 1'b1;
                    m_miss  = 0;
                end
            end
        end else if (m_halt) begin
            if (rs) begin
                m_halt  = 1'b0;
                m_fetch = 1'b1;
                m_miss  = 0;
            end
        end
        m_pc = exp_nx;
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] rt;
        int          req_cnt;
        rst = 1'b0;
        drive_idle();
        model_reset();

        // Zero-wait sequential run and stall with pending redirect.
        do_reset();
        plain(6);
        #1 chk("seq_pc8", pc_q, 16'h0008);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
        #1 chk("redir_pc", pc_q, 16'h0040);
        plain(1);

        // Halt at 0x0010 then resume.
        cycle(1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
        plain(1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        #1 chk("halt_pc", pc_q, 16'h0014);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        plain(2);

        // Fetch timeout: count req cycles directly.
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            if (imem_req) req_cnt++;
        end
        chk("timeout_req_cycles", 16'(req_cnt), 16'd15);
        chk("timeout_fault", 16'(fault), 16'h1);
        do_reset();
        #1 chk("post_fault_pc", pc_q, RST_PC);

        // Misaligned redirect faults with the PC held.
        plain(2);
        cycle(1'b1, 1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
        #1 chk("misalign_pc", pc_q, 16'h0000);
        plain(3);
        do_reset();

        // Wrap from 0xFFFC to 0x0000.
        plain(2);
        cycle(1'b1, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0);
        plain(2);
        #1 chk("wrap_pc", pc_q, 16'h0000);
        plain(3);

        // Asynchronous reset in the middle of a pending fetch.
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1 chk("midfetch_req_before", 16'(imem_req), 16'h1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midfetch");
        @(posedge clk);
        imem_ack = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        plain(4);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rt = 16'($urandom);
                if ($urandom_range(0, 15) != 0) rt[1:0] = 2'b00;
                cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0, rt, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) < 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
